// File: rtl/shared_bus_reader.sv
// shared_bus_reader
//
// Read-side sequencer for a shared tri-state bus. It enables one driver at a
// time through the one-hot `en` vector and keeps it on for SETTLE+1 cycles.
// It then captures the resolved bus value and offers it downstream with a
// valid/ready handshake. At least one all-off cycle (the HOLD cycle)
// separates consecutive drivers, so two drivers never overlap on the bus.
//
// Optional feature: define SHARED_BUS_ACCUM_EN to add a running signed sum
// of the words captured in the current scan.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   start      begin one scan of all sources (ignored while busy)
//   bus_in     resolved shared bus value
//   en         one-hot driver enables, all-zero when not driving
//   out_data   captured bus word
//   out_src    index of the source that produced out_data
//   out_valid  out_data/out_src valid
//   out_ready  downstream accepts the word on out_valid & out_ready
//   busy       high from start acceptance until the cycle after done
//   done       one-cycle pulse after the last word is accepted
//   acc_sum    (SHARED_BUS_ACCUM_EN) signed sum of the scan's words
//   acc_valid  (SHARED_BUS_ACCUM_EN) qualifies acc_sum, pulses with done
//
// Every output is driven straight from a flop. No input has a
// combinational path to any output.

module shared_bus_reader #(
  parameter  int NUM_SRC = 8,
  parameter  int WIDTH   = 21,
  parameter  int SETTLE  = 1,
  localparam int SRC_W   = $clog2(NUM_SRC)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   bus_in,
  output logic [NUM_SRC-1:0] en,
  output logic [WIDTH-1:0]   out_data,
  output logic [SRC_W-1:0]   out_src,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               done
`ifdef SHARED_BUS_ACCUM_EN
  ,
  output logic signed [WIDTH+SRC_W-1:0] acc_sum,
  output logic                          acc_valid
`endif
);

  typedef enum logic [1:0] {IDLE, DRIVE, HOLD, DONE} state_t;

  state_t             state, state_n;
  logic [SRC_W-1:0]   idx, idx_n;
  logic [3:0]         cnt, cnt_n;
  logic [NUM_SRC-1:0] en_n;
  logic [WIDTH-1:0]   data_n;
  logic [SRC_W-1:0]   src_n;
  logic               valid_n, busy_n, done_n;

`ifdef SHARED_BUS_ACCUM_EN
  logic signed [WIDTH+SRC_W-1:0] acc_sum_n;
  logic                          acc_valid_n;
`endif

  function automatic logic [NUM_SRC-1:0] onehot(input logic [SRC_W-1:0] i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

  always_comb begin
    // NOTE: every signal gets a default before the case. This makes the
    // block purely combinational, and no path can leave a value
    // unassigned and infer a latch.
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    en_n    = en;
    data_n  = out_data;
    src_n   = out_src;
    valid_n = out_valid;
    busy_n  = busy;
    done_n  = 1'b0;
`ifdef SHARED_BUS_ACCUM_EN
    acc_sum_n   = acc_sum;
    acc_valid_n = 1'b0;
`endif

    unique case (state)
      IDLE: begin
        en_n   = '0;
        busy_n = 1'b0;
        if (start) begin
          state_n = DRIVE;
          idx_n   = '0;
          cnt_n   = '0;
          en_n    = onehot('0);
          busy_n  = 1'b1;
`ifdef SHARED_BUS_ACCUM_EN
          acc_sum_n = '0;
`endif
        end
      end

      DRIVE: begin
        if (cnt == 4'(SETTLE)) begin
          // The bus has settled. Capture it and release the driver on the
          // same edge, so the following HOLD cycle is the turnaround.
          data_n  = bus_in;
          src_n   = idx;
          valid_n = 1'b1;
          en_n    = '0;
          state_n = HOLD;
`ifdef SHARED_BUS_ACCUM_EN
          acc_sum_n = acc_sum + {{SRC_W{bus_in[WIDTH-1]}}, bus_in};
`endif
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end

      HOLD: begin
        if (out_valid && out_ready) begin
          valid_n = 1'b0;
          if (idx == SRC_W'(NUM_SRC - 1)) begin
            state_n = DONE;
            done_n  = 1'b1;
`ifdef SHARED_BUS_ACCUM_EN
            acc_valid_n = 1'b1;
`endif
          end else begin
            idx_n   = idx + 1'b1;
            cnt_n   = '0;
            en_n    = onehot(idx + 1'b1);
            state_n = DRIVE;
          end
        end
      end

      DONE: begin
        state_n = IDLE;
        busy_n  = 1'b0;
        en_n    = '0;
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments. All flops then
    // sample the pre-edge values, whatever order the assignments are in.
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      cnt       <= '0;
      en        <= '0;
      out_data  <= '0;
      out_src   <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef SHARED_BUS_ACCUM_EN
      acc_sum   <= '0;
      acc_valid <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      cnt       <= cnt_n;
      en        <= en_n;
      out_data  <= data_n;
      out_src   <= src_n;
      out_valid <= valid_n;
      busy      <= busy_n;
      done      <= done_n;
`ifdef SHARED_BUS_ACCUM_EN
      acc_sum   <= acc_sum_n;
      acc_valid <= acc_valid_n;
`endif
    end
  end

endmodule

// File: tb/tb_shared_bus_reader.sv
// Directed testbench for shared_bus_reader (NUM_SRC=4, SETTLE=1).
// The bench models the tri-state drivers as a mux selected by `en`.
// When no driver is enabled, the bus carries a recognisable junk value.

module tb_shared_bus_reader;

  localparam int NUM_SRC = 4;
  localparam int WIDTH   = 21;
  localparam int SETTLE  = 1;
  localparam int SRC_W   = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [WIDTH-1:0]   bus_in;
  logic [NUM_SRC-1:0] en;
  logic [WIDTH-1:0]   out_data;
  logic [SRC_W-1:0]   out_src;
  logic               out_valid;
  logic               out_ready;
  logic               busy;
  logic               done;
`ifdef SHARED_BUS_ACCUM_EN
  logic signed [WIDTH+SRC_W-1:0] acc_sum;
  logic                          acc_valid;
`endif

  int checks   = 0;
  int failures = 0;

  logic [WIDTH-1:0] words [NUM_SRC];

  shared_bus_reader #(.NUM_SRC(NUM_SRC), .WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bus_in    (bus_in),
    .en        (en),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
`ifdef SHARED_BUS_ACCUM_EN
    ,
    .acc_sum   (acc_sum),
    .acc_valid (acc_valid)
`endif
  );

  always #5 clk = ~clk;

  // Tri-state driver model: the enabled source drives the bus.
  always_comb begin
    bus_in = 21'h0ABCD;
    for (int i = 0; i < NUM_SRC; i++)
      if (en[i]) bus_in = words[i];
  end

  // Bus contention monitor: at most one driver, and a turnaround between drivers.
  logic [NUM_SRC-1:0] prev_en = '0;
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      checks++;
      if ($countones(en) > 1) begin
        failures++;
        $display("FAIL en_onehot: en=%b has more than one bit set", en);
      end
      if (en != '0 && prev_en != '0 && en != prev_en) begin
        failures++;
        $display("FAIL turnaround: en went %b -> %b with no all-zero cycle", prev_en, en);
      end
    end
    prev_en = en;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int max);
    int n = 0;
    while (!out_valid && n < max) begin
      step();
      n++;
    end
    checks++;
    if (!out_valid) begin
      failures++;
      $display("FAIL %s: out_valid not seen within %0d cycles", name, max);
    end
  endtask

  // Waits for the done pulse, then steps once so the DUT is back in IDLE.
  task automatic wait_done(input string name, input int max);
    int n = 0;
    while (!done && n < max) begin
      step();
      n++;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s: done not seen within %0d cycles", name, max);
    end
    step();
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; out_ready = 1'b1;
    step();
    step();
    checks++;
    if (en !== '0 || out_data !== '0 || out_src !== '0 || out_valid !== 1'b0 ||
        busy !== 1'b0 || done !== 1'b0)
      begin
        failures++;
        $display("FAIL reset_outputs: en=%b data=%h src=%0d valid=%b busy=%b done=%b, expected all 0",
                 en, out_data, out_src, out_valid, busy, done);
      end
    rst = 1'b0;
    step();
    checks++;
    if (en !== '0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_no_start: en=%b busy=%b, expected 0/0", en, busy);
    end
  endtask

  task automatic test_basic_scan;
    logic [NUM_SRC-1:0] exp_en;
    logic               exp_v, exp_done, exp_busy;
    int                 w;
    words = '{21'h00001, 21'h00002, 21'h00003, 21'h1FFFFF};
    out_ready = 1'b1;
    do_start();  // now in cycle k+1
    for (int c = 1; c <= 14; c++) begin
      exp_en = '0; exp_v = 1'b0; w = 0;
      exp_done = (c == 13);
      exp_busy = (c <= 13);
      if (c <= 12) begin
        w = (c - 1) / 3;
        if ((c - 1) % 3 < 2) exp_en = NUM_SRC'(1 << w);
        else                 exp_v  = 1'b1;
      end
      checks++;
      if (en !== exp_en || out_valid !== exp_v || done !== exp_done || busy !== exp_busy) begin
        failures++;
        $display("FAIL basic_ctrl k+%0d: en=%b valid=%b done=%b busy=%b, expected en=%b valid=%b done=%b busy=%b",
                 c, en, out_valid, done, busy, exp_en, exp_v, exp_done, exp_busy);
      end
      if (exp_v) begin
        checks++;
        if (out_src !== SRC_W'(w) || out_data !== words[w]) begin
          failures++;
          $display("FAIL basic_word k+%0d: src=%0d data=%h, expected src=%0d data=%h",
                   c, out_src, out_data, w, words[w]);
        end
      end
      step();
    end
  endtask

  task automatic test_backpressure;
    words = '{21'h00001, 21'h00002, 21'h00003, 21'h00004};
    out_ready = 1'b0;
    do_start();
    wait_valid("bp_word0", 10);
    checks++;
    if (out_src !== 2'd0 || out_data !== 21'h00001) begin
      failures++;
      $display("FAIL bp_word0: src=%0d data=%h, expected 0/00001", out_src, out_data);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    wait_valid("bp_word1", 10);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_src !== 2'd1 || out_data !== 21'h00002 || en !== '0) begin
        failures++;
        $display("FAIL bp_hold cycle %0d: valid=%b src=%0d data=%h en=%b, expected 1/1/00002/0000",
                 i, out_valid, out_src, out_data, en);
      end
      step();
    end
    out_ready = 1'b1;
    checks++;
    if (en !== '0) begin
      failures++;
      $display("FAIL bp_release_same_cycle: en=%b, expected 0000", en);
    end
    step();
    checks++;
    if (en !== 4'b0100 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_next_driver: en=%b valid=%b, expected 0100/0", en, out_valid);
    end
    wait_done("bp_done", 30);
  endtask

  task automatic test_contention;
    int  nwords = 0;
    bit  seen_done = 1'b0;
    words = '{21'h10101, 21'h02020, 21'h00303, 21'h14040};
    out_ready = 1'b0;
    do_start();
    for (int n = 0; n < 200 && !seen_done; n++) begin
      if (done) begin
        seen_done = 1'b1;
      end else begin
        out_ready = 1'($urandom_range(0, 1));
        if (out_valid && out_ready) begin
          checks++;
          if (out_src !== SRC_W'(nwords) || out_data !== words[nwords]) begin
            failures++;
            $display("FAIL cont_word %0d: src=%0d data=%h, expected src=%0d data=%h",
                     nwords, out_src, out_data, nwords, words[nwords]);
          end
          nwords++;
        end
        step();
      end
    end
    checks++;
    if (!seen_done || nwords != NUM_SRC) begin
      failures++;
      $display("FAIL cont_count: done_seen=%0b words=%0d, expected 1/%0d", seen_done, nwords, NUM_SRC);
    end
    out_ready = 1'b1;
    step();
  endtask

  task automatic test_reset_mid_scan;
    int n = 0;
    words = '{21'h00011, 21'h00022, 21'h00033, 21'h00044};
    out_ready = 1'b1;
    do_start();
    while (en !== 4'b0100 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (en !== 4'b0100) begin
      failures++;
      $display("FAIL rstmid_reach_src2: en=%b, expected 0100", en);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (en !== '0 || out_data !== '0 || out_src !== '0 || out_valid !== 1'b0 ||
        busy !== 1'b0 || done !== 1'b0)
      begin
        failures++;
        $display("FAIL rstmid_outputs: en=%b data=%h src=%0d valid=%b busy=%b done=%b, expected all 0",
                 en, out_data, out_src, out_valid, busy, done);
      end
    step();
    checks++;
    if (en !== '0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_idle: en=%b busy=%b, expected 0/0", en, busy);
    end
    do_start();
    checks++;
    if (en !== 4'b0001 || busy !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_restart_en: en=%b busy=%b, expected 0001/1", en, busy);
    end
    wait_valid("rstmid_restart", 10);
    checks++;
    if (out_src !== 2'd0 || out_data !== 21'h00011) begin
      failures++;
      $display("FAIL rstmid_restart_word: src=%0d data=%h, expected 0/00011", out_src, out_data);
    end
    wait_done("rstmid_done", 30);
  endtask

  task automatic test_start_ignored;
    int nwords = 0;
    bit seen_done = 1'b0;
    words = '{21'h0000A, 21'h0000B, 21'h0000C, 21'h0000D};
    out_ready = 1'b1;
    start = 1'b1;
    step();      // accepted here
    step();      // still high during first DRIVE cycle: must be ignored
    start = 1'b0;
    for (int n = 0; n < 60 && !seen_done; n++) begin
      if (done) begin
        seen_done = 1'b1;
        start = 1'b1;  // sampled on the edge leaving DONE: must be ignored
        step();
        start = 1'b0;
      end else begin
        if (out_valid && out_ready) begin
          checks++;
          if (out_src !== SRC_W'(nwords)) begin
            failures++;
            $display("FAIL ign_src %0d: src=%0d, expected %0d", nwords, out_src, nwords);
          end
          nwords++;
        end
        step();
      end
    end
    checks++;
    if (!seen_done || nwords != NUM_SRC) begin
      failures++;
      $display("FAIL ign_count: done_seen=%0b words=%0d, expected 1/%0d", seen_done, nwords, NUM_SRC);
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (busy !== 1'b0 || en !== '0) begin
        failures++;
        $display("FAIL ign_after_done %0d: busy=%b en=%b, expected 0/0000", i, busy, en);
      end
      step();
    end
  endtask

`ifdef SHARED_BUS_ACCUM_EN
  task automatic test_accum;
    int n = 0;
    words = '{21'h00005, 21'h1FFFFE, 21'h00010, 21'h1FFFFF};
    out_ready = 1'b1;
    do_start();
    while (!done && n < 30) begin
      step();
      n++;
    end
    checks++;
    if (done !== 1'b1 || acc_valid !== 1'b1 || acc_sum !== 23'sd18) begin
      failures++;
      $display("FAIL acc_at_done: done=%b acc_valid=%b acc_sum=%0d, expected 1/1/18",
               done, acc_valid, acc_sum);
    end
    step();
    checks++;
    if (acc_valid !== 1'b0 || acc_sum !== 23'sd18) begin
      failures++;
      $display("FAIL acc_hold: acc_valid=%b acc_sum=%0d, expected 0/18", acc_valid, acc_sum);
    end
    do_start();
    checks++;
    if (acc_sum !== 23'sd0 || acc_valid !== 1'b0) begin
      failures++;
      $display("FAIL acc_clear: acc_sum=%0d acc_valid=%b, expected 0/0", acc_sum, acc_valid);
    end
    wait_done("acc_done", 30);
  endtask
`endif

  initial begin
    rst = 1'b1; start = 1'b0; out_ready = 1'b1;
    words = '{21'h0, 21'h0, 21'h0, 21'h0};
    test_reset();
    test_basic_scan();
    test_backpressure();
    test_contention();
    test_reset_mid_scan();
    test_start_ignored();
`ifdef SHARED_BUS_ACCUM_EN
    test_accum();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shared_bus_reader.md
Name: shared_bus_reader

Overview:
- Read-side sequencer for the 21-bit shared tri-state bus used between neuron stages.
- Drives a one-hot `en` vector into the `control` pins of NUM_SRC tri-state drivers, one driver at a time. Waits a settle interval, then captures the resolved bus value.
- Presents each captured word downstream with a valid/ready handshake.
- Guarantees at most one driver is enabled in any cycle, with at least one all-off turnaround cycle between drivers.

Parameters:
- NUM_SRC, 8, number of tri-state drivers on the bus (2..32).
- WIDTH, 21, bus width in bits.
- SETTLE, 1, extra cycles `en` stays high before capture (0..15).
- Localparam SRC_W = $clog2(NUM_SRC).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin one scan of all sources; ignored while busy=1.
- bus_in  input  WIDTH  resolved shared bus (wired to all driver outputs).
- en  output  NUM_SRC  one-hot driver enables; all-zero when not driving.
- out_data  output  WIDTH  captured bus word.
- out_src  output  SRC_W  index of the source that produced out_data.
- out_valid  output  1  out_data/out_src valid.
- out_ready  input  1  downstream accepts the word when out_valid & out_ready.
- busy  output  1  high from start acceptance until the cycle after done.
- done  output  1  one-cycle pulse after the last word is accepted.

Behaviour:
- Reset: on a rising edge with rst=1, all outputs go to 0 (en=0, out_data=0, out_src=0, out_valid=0, busy=0, done=0), state=IDLE, idx=0, settle counter=0. Reset mid-scan aborts immediately; a word held in the output register is discarded.
- FSM states: IDLE, DRIVE, HOLD, DONE.
- IDLE:
  - en=0, busy=0.
  - start=1 at edge k → DRIVE from cycle k+1, idx=0, busy=1.
- DRIVE:
  - en = 1<<idx for exactly SETTLE+1 cycles.
  - On the edge ending the last DRIVE cycle: out_data ← bus_in, out_src ← idx, out_valid ← 1, en ← 0, go to HOLD.
  - Latency with SETTLE=1: en[0] high in cycles k+1 and k+2; out_valid high from cycle k+3.
- HOLD:
  - en=0 (this cycle is the bus turnaround).
  - out_data and out_src stay stable while out_valid=1 and out_ready=0.
  - On a handshake with idx<NUM_SRC-1: out_valid ← 0, idx ← idx+1, go to DRIVE. The next en is asserted in the cycle after the handshake, so at least one all-zero en cycle always separates drivers.
  - On a handshake with idx=NUM_SRC-1: out_valid ← 0, go to DONE.
- DONE:
  - done=1 for one cycle, busy still 1; then IDLE with busy=0.
  - start during DONE is ignored.
- out_ready may be held high permanently. Throughput is then one word per SETTLE+2 cycles.
- No combinational path from any input to any output; all outputs are registered.
- `en` must never have more than one bit set. A violation is a bench assertion failure.
- `bus_in` is sampled raw; a floating (z/x) capture is passed through unchanged in simulation.

Optional Feature:
- Macro: SHARED_BUS_ACCUM_EN.
- When defined, adds two ports:
  - acc_sum  output  WIDTH+SRC_W  signed sum of all words in the current scan.
  - acc_valid  output  1  qualifies acc_sum.
- acc_sum and acc_valid are cleared to 0 on reset and on start acceptance.
- Each capture adds the sign-extended bus_in to acc_sum on the same edge that loads out_data.
- acc_valid pulses together with done; acc_sum holds its value until the next start.
- When undefined, both ports and the adder are absent; all other behaviour is identical.

Test Plan:
- Basic scan: NUM_SRC=4, SETTLE=1, drivers hold 21'h00001/00002/00003/1FFFFF, out_ready=1, start pulse → out_src=0..3 and out_data as driven; out_valid cycles k+3, k+6, k+9, k+12; done at k+13; busy drops at k+14.
- Backpressure: out_ready=0 for 5 cycles on word 1 → out_data=21'h00002 and out_src=1 held stable; en=0 throughout; en[2] is not asserted until the cycle after out_ready rises.
- Contention: monitor en over a full scan with random out_ready → $countones(en)≤1 every cycle; at least one en=0 cycle between different drivers.
- Reset mid-scan: assert rst while en[2]=1 → next cycle all outputs are 0 and the state is IDLE; a new start then scans from src 0.
- Start ignored: pulse start while busy=1 (in DRIVE and in DONE) → no restart and exactly NUM_SRC words per scan.
- SHARED_BUS_ACCUM_EN: words 21'h00005, 21'h1FFFFE (−2), 21'h00010, 21'h1FFFFF (−1) → acc_sum=18 with acc_valid=1 coincident with done; acc_sum is 0 after the next start.
